// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// default halt encoding, the ARMv8 NOP and a saturating counter helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hD440_0000;
  localparam logic [31:0] ARM_NOP           = 32'hD503_201F;
  localparam logic [63:0] PC_STEP           = 64'd4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear has priority over load, otherwise the
// contents hold.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [63:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [63:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [63:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  // Next-state selection: clear, load or hold.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (clear_i) begin
      pc_d    = 64'd0;
      instr_d = 32'd0;
      valid_d = 1'b0;
    end else if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end else begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= 64'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT control and IF/ID
// register. Optional performance counters under FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
)(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [63:0] BranchTarget,
  output logic [63:0] Address,
  input  logic [31:0] Instruction,
  output logic [63:0] IFID_PC,
  output logic [31:0] IFID_Instruction,
  output logic        IFID_Valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount,
`endif
  output logic        Halted
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  redirect_pc_s;
  logic         ifid_load_s;
  logic         ifid_clear_s;
  logic         stall_edge_s;
  logic         tgt_unused_s;

  // Redirects are word aligned; the low target bits are dropped.
  assign redirect_pc_s = {BranchTarget[63:2], 2'b00};
  assign tgt_unused_s  = ^BranchTarget[1:0];

  // Next-state, next-PC and IF/ID control, in priority order.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_load_s  = 1'b0;
    ifid_clear_s = 1'b0;
    stall_edge_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (BranchTaken) begin
          pc_d         = redirect_pc_s;
          ifid_clear_s = 1'b1;
        end else if (Flush) begin
          ifid_clear_s = 1'b1;
        end else if (Stall) begin
          stall_edge_s = 1'b1;
        end else begin
          ifid_load_s = 1'b1;
          if (Instruction == HALT_WORD) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      ST_HALT: begin
        ifid_clear_s = 1'b1;
        if (BranchTaken) begin
          pc_d    = redirect_pc_s;
          state_d = ST_RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // PC and FSM state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .load_i  (ifid_load_s),
    .clear_i (ifid_clear_s),
    .pc_i    (pc_q),
    .instr_i (Instruction),
    .pc_o    (IFID_PC),
    .instr_o (IFID_Instruction),
    .valid_o (IFID_Valid)
  );

  assign Address = {2'b00, pc_q[63:2]};
  assign Halted  = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Saturating counts of IF/ID loads and RUN-state stall-only edges.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (ifid_load_s) begin
        fetch_cnt_q <= sat_inc32(fetch_cnt_q);
      end else begin
        fetch_cnt_q <= fetch_cnt_q;
      end
      if (stall_edge_s) begin
        stall_cnt_q <= sat_inc32(stall_cnt_q);
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign StallCount = stall_cnt_q;
`endif

endmodule
